zmod_rx_align: RTL
==================

Name: zmod_rx_align

Overview:
- Parametrised receive-side word aligner and link checker for the zmod source-synchronous LVDS link.
- Sits in the rxdivclk domain directly after the per-lane ISERDESE3 deserialisers. Takes one framing (sync) lane and N data lanes.
- Finds the bit offset of the one-hot sync word, qualifies it through a hunt/verify/lock state machine, then freezes the offset and barrel-shifts all data lanes.
- Checks each lane for an incrementing-count pattern and reports per-lane error counts and relock events to the ILA or register space.

Parameters:
- N, 3, number of data lanes (1..8).
- W, 8, deserialisation width in bits per lane word (4 or 8).
- LOCK_CNT, 4, consecutive good sync words at a consistent offset required to enter LOCKED (2..255).
- MISS_CNT, 3, consecutive bad sync words in LOCKED that force return to HUNT (1..255).
- CNT_W, 16, width of the error and relock counters.

Ports:
- clk  in  1  rxdivclk, the divided receive clock.
- rst_n  in  1  asynchronous active-low reset.
- sync_in  in  W  deserialised sync-lane word (LSB = first received bit).
- data_in  in  N*W  deserialised data-lane words; lane i occupies [i*W +: W].
- err_clr  in  1  synchronous clear of all err_cnt and of relock_cnt.
- dout  out  N*W  aligned data words.
- dout_valid  out  1  dout is aligned under a locked offset.
- locked  out  1  state == LOCKED.
- shift  out  $clog2(W)  current frozen bit offset.
- err_flag  out  N  per-lane mismatch flag for the current dout word.
- err_cnt  out  N*CNT_W  per-lane saturating mismatch counters.
- relock_cnt  out  CNT_W  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Reset values: all outputs 0, state = HUNT, all history registers 0.
- Stage A (every clk):
  - hist_q[i] <= {data_in[i], hist_q[i][2W-1:W]}
  - sync_hist_q <= {sync_in, sync_hist_q[2W-1:W]}
- Candidate offset: k = index of the set bit when sync_hist_q[W-1:0] is one-hot. If it is not one-hot, no candidate exists.
- Aligned sync word: asw = (sync_hist_q >> k_eff)[W-1:0], where k_eff is the frozen shift in VERIFY/LOCKED and the candidate k in HUNT. A sync word is good iff asw == 1.
- HUNT:
  - Good sync with a candidate: shift <= k, good count <= 1, go to VERIFY.
  - Otherwise: stay.
- VERIFY:
  - Good sync at the frozen shift: good count +1. When the count reaches LOCK_CNT, go to LOCKED with miss count <= 0.
  - Any bad sync: go to HUNT.
- LOCKED:
  - Good sync: miss count <= 0.
  - Bad sync: miss count +1. When it reaches MISS_CNT, go to HUNT and increment relock_cnt (saturating).
  - shift never changes while in LOCKED.
- Stage B:
  - dout[i] <= (hist_q[i] >> shift)[W-1:0]
  - dout_valid <= (state == LOCKED)
  - Latency from data_in to dout is 2 clk.
- Checker, per lane, evaluated when dout_valid:
  - Expected word = previous dout[i] + 1, modulo 2^W.
  - The first dout_valid cycle after any 0->1 edge of dout_valid only primes the previous value: no compare, err_flag = 0.
  - On mismatch: err_flag[i] = 1 for that cycle and err_cnt[i] +1, saturating at 2^CNT_W-1.
  - err_flag is 0 whenever dout_valid is 0.
- err_clr: counters go to 0 on the next clk. If err_clr coincides with an increment event, the clear wins.
- Wrap-around: W'hFF -> W'h00 is a correct increment, not an error.
- Reset mid-operation: state immediately returns to HUNT, dout_valid and locked go to 0, counters clear.

Decomposition:
- Package zmod_pkg holds:
  - typedef enum logic[1:0] {HUNT, VERIFY, LOCKED} align_state_t;
  - the sync pattern constant SYNC_WORD = 1;
  - function onehot_idx(W-bit) returning {valid, index}.
- Sub-module zmod_lane_check, instantiated N times, holds the per-lane previous word, prime flag, err_flag and saturating err_cnt.

Test Plan (all with N=3, W=8, LOCK_CNT=4, MISS_CNT=3, CNT_W=16):
- Serialised sync 8'h01 per frame and lanes counting from 8'h00, bitstream skewed by 3 bits -> locked rises exactly 4 good sync words after the first detection, shift=3, dout lanes read consecutive counts, err_cnt all 0.
- While locked, corrupt 2 consecutive sync words, then resume -> locked stays 1, shift unchanged, relock_cnt=0.
- While locked, corrupt 3 consecutive sync words -> locked falls, relock_cnt=1, dout_valid=0. Then relock at a new skew of 6 -> shift=6.
- While locked, flip one bit of lane 1 in a single frame -> err_flag[1] pulses on two consecutive cycles (bad word, then the following word), err_cnt[1]=2, lanes 0 and 2 remain 0.
- Lane count passes 8'hFF -> 8'h00 -> no error. Assert err_clr in the same cycle as an injected error -> err_cnt reads 0 on the next cycle.
- Drop rst_n asynchronously mid-VERIFY and mid-LOCKED -> all outputs read 0 before the next clk edge. After release, the block relocks in LOCK_CNT sync words.

Source files
------------

// File: rtl/zmod_pkg.sv
// Shared types and helpers for the zmod receive aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zmod_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    localparam int SYNC_WORD = 1;

    // Word is zero-extended to 8 bits by the caller; returns {valid, index}.
    function automatic logic [3:0] onehot_idx(input logic [7:0] w);
        logic [3:0] ones;
        logic [2:0] idx;
        ones = '0;
        idx  = '0;
        for (int b = 0; b < 8; b++) begin
            if (w[b]) begin
                ones = ones + 4'd1;
                idx  = 3'(b);
            end
        end
        return {(ones == 4'd1), idx};
    endfunction

endpackage

// File: rtl/zmod_lane_check.sv
// Per-lane incrementing-count checker with saturating error counter.
// Latency: err_flag combinational on the presented word; err_cnt updates one clk later.
// Backpressure: none, evaluates every clk that din_vld is high.
module zmod_lane_check
    import zmod_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     din_dat,
    input  logic             din_vld,
    input  logic             err_clr,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt
);

    logic [W-1:0]     prev_q;
    logic             primed_q;
    logic [CNT_W-1:0] cnt_q;

    // The first valid word after a gap has nothing to compare against.
    assign err_flag = din_vld && primed_q && (din_dat != (prev_q + W'(1)));
    assign err_cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            primed_q <= din_vld;
            if (din_vld) begin
                prev_q <= din_dat;
            end
            if (err_clr) begin
                cnt_q <= '0;
            end else if (err_flag && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/zmod_rx_align.sv
// Sync-lane word aligner, lock FSM and per-lane count checker for the zmod LVDS receiver.
// Latency: data_in to dout 2 clk; err_flag valid alongside dout.
// Backpressure: none, free-running stream in the rxdivclk domain.
module zmod_rx_align
    import zmod_pkg::*;
#(
    parameter int N        = 3,
    parameter int W        = 8,
    parameter int LOCK_CNT = 4,
    parameter int MISS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           sync_in,
    input  logic [N*W-1:0]         data_in,
    input  logic                   err_clr,
    output logic [N*W-1:0]         dout,
    output logic                   dout_valid,
    output logic                   locked,
    output logic [$clog2(W)-1:0]   shift,
    output logic [N-1:0]           err_flag,
    output logic [N*CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]       relock_cnt
);

    localparam int SW = $clog2(W);
    localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
    localparam logic [7:0] MISS_N = 8'(MISS_CNT);

    logic [2*W-1:0] hist_q [N];
    logic [2*W-1:0] sync_hist_q;

    align_state_t   state_q, state_d;
    logic [SW-1:0]  shift_q, shift_d;
    logic [7:0]     good_q, good_d;
    logic [7:0]     miss_q, miss_d;
    logic           relock_inc;
    logic [CNT_W-1:0] relock_q;

    logic [3:0]     oh;
    logic           cand_vld;
    logic [SW-1:0]  cand_k;
    logic [SW-1:0]  k_eff;
    logic [W-1:0]   asw;
    logic           sync_good;

    logic [N*W-1:0] dout_q;
    logic           dout_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_hist_q <= '0;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            sync_hist_q <= {sync_in, sync_hist_q[2*W-1:W]};
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= {data_in[i*W +: W], hist_q[i][2*W-1:W]};
            end
        end
    end

    // Older word sits in the low half, so the window at offset k spans both words.
    assign oh        = onehot_idx(8'(sync_hist_q[W-1:0]));
    assign cand_vld  = oh[3];
    assign cand_k    = oh[SW-1:0];
    assign k_eff     = (state_q == HUNT) ? cand_k : shift_q;
    assign asw       = W'(sync_hist_q >> k_eff);
    assign sync_good = (asw == W'(SYNC_WORD));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        good_d     = good_q;
        miss_d     = miss_q;
        relock_inc = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync_good && cand_vld) begin
                    shift_d = cand_k;
                    good_d  = 8'd1;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (sync_good) begin
                    good_d = good_q + 8'd1;
                    if ((good_q + 8'd1) == LOCK_N) begin
                        state_d = LOCKED;
                        miss_d  = 8'd0;
                    end
                end else begin
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (sync_good) begin
                    miss_d = 8'd0;
                end else begin
                    miss_d = miss_q + 8'd1;
                    if ((miss_q + 8'd1) == MISS_N) begin
                        state_d    = HUNT;
                        relock_inc = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            shift_q <= '0;
            good_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (err_clr) begin
            relock_q <= '0;
        end else if (relock_inc && (relock_q != '1)) begin
            relock_q <= relock_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                dout_q[i*W +: W] <= W'(hist_q[i] >> shift_q);
            end
            dout_valid_q <= (state_q == LOCKED);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        zmod_lane_check #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_chk (
            .clk      (clk),
            .rst_n    (rst_n),
            .din_dat  (dout_q[i*W +: W]),
            .din_vld  (dout_valid_q),
            .err_clr  (err_clr),
            .err_flag (err_flag[i]),
            .err_cnt  (err_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = (state_q == LOCKED);
    assign shift      = shift_q;
    assign relock_cnt = relock_q;

endmodule
